// File: rtl/neuron_pkg.sv
// neuron_pkg: shared definitions for the streaming neuron MAC.
//   state_t     - 2-bit FSM state encoding (IDLE/ACCUM/FINISH/OUTPUT)
//   clog2       - ceiling log2 usable in parameter expressions
//   acc_width   - accumulator width that cannot overflow for a frame
//   sat_max/min - signed saturation bounds for a given value width
package neuron_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        FINISH = 2'd2,
        OUTPUT = 2'd3
    } state_t;

    // clog2(1) = 0, clog2(2) = 1, clog2(5) = 3 ...
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Full product width, plus one bit per doubling of terms, plus a guard
    // bit that also absorbs the shifted bias.
    function automatic int acc_width(input int resolution, input int input_data_size);
        return 2 * resolution + clog2(input_data_size) + 1;
    endfunction

    function automatic longint sat_max(input int resolution);
        return (longint'(1) << (resolution - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int resolution);
        return -(longint'(1) << (resolution - 1));
    endfunction

endpackage

// File: rtl/dff_nbit.sv
// dff_nbit: n-bit register with synchronous active-high reset and enable.
//   clk   - rising-edge clock
//   reset - synchronous clear to zero
//   en    - load d when high, otherwise hold
//   d / q - data in / registered data out
module dff_nbit #(
    parameter int n = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [n-1:0] d,
    output logic [n-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/neuron_stream_mac_lane_dot_product.sv
// lane_dot_product: combinational dot product of one beat.
//   input_data / weight - lanes signed values, lane k at [k*resolution +: resolution]
//   lane_mask           - lane k contributes only when lane_mask[k] is set
//   beat_sum            - signed sum of the unmasked lane products
module lane_dot_product
    import neuron_pkg::*;
#(
    parameter int lanes      = 4,
    parameter int resolution = 8
) (
    input  logic [resolution*lanes-1:0]                   input_data,
    input  logic [resolution*lanes-1:0]                   weight,
    input  logic [lanes-1:0]                              lane_mask,
    output logic signed [2*resolution+clog2(lanes)-1:0]   beat_sum
);

    localparam int sum_w = 2 * resolution + clog2(lanes);

    logic signed [2*resolution-1:0] prod [lanes];

    always_comb begin
        beat_sum = '0;
        for (int k = 0; k < lanes; k++) begin
            prod[k] = $signed(input_data[k*resolution +: resolution]) *
                      $signed(weight[k*resolution +: resolution]);
            if (lane_mask[k]) begin
                // Size cast of a signed operand sign-extends.
                beat_sum = beat_sum + sum_w'(prod[k]);
            end
        end
    end

endmodule

// File: rtl/neuron_stream_mac.sv
// neuron_stream_mac: streaming neuron, ReLU/saturate(sum(x*w) + bias).
//   clk, reset         - clock, synchronous active-high reset
//   in_valid/in_ready  - input beat handshake (lanes elements per beat)
//   input_data, weight - packed signed lanes; bias sampled on a frame's first beat
//   out_valid/out_ready- result handshake; output_neuron held until accepted
//   output_neuron      - signed fixed-point result
//   busy               - frame in progress (state is not IDLE)
//   dbg_state          - current FSM state for observation
// Both handshakes transfer on a cycle where valid and ready are both high at
// the rising edge; valid never waits on ready, and an offered output stays
// stable until taken.
module neuron_stream_mac
    import neuron_pkg::*;
#(
    parameter int input_data_size = 784,
    parameter int lanes           = 4,
    parameter int resolution      = 8,
    parameter int frac_bits       = 6,
    parameter int relu_en         = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [resolution*lanes-1:0]   input_data,
    input  logic [resolution*lanes-1:0]   weight,
    input  logic [resolution-1:0]         bias,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [resolution-1:0]         output_neuron,
    output logic                          busy,
    output logic [1:0]                    dbg_state
);

    localparam int beats  = (input_data_size + lanes - 1) / lanes;
    localparam int cnt_w  = (clog2(beats + 1) < 1) ? 1 : clog2(beats + 1);
    localparam int acc_w  = acc_width(resolution, input_data_size);
    localparam int sum_w  = 2 * resolution + clog2(lanes);
    localparam logic signed [acc_w-1:0] sat_hi = acc_w'(sat_max(resolution));
    localparam logic signed [acc_w-1:0] sat_lo = acc_w'(sat_min(resolution));
    localparam logic [cnt_w-1:0] last_cnt = cnt_w'(beats - 1);

    state_t                        state, state_next;
    logic signed [acc_w-1:0]       acc;
    logic [cnt_w-1:0]              cnt;
    logic signed [resolution-1:0]  bias_q;
    logic [lanes-1:0]              lane_mask;
    logic signed [sum_w-1:0]       beat_sum;
    logic signed [acc_w-1:0]       biased, shifted;
    logic [resolution-1:0]         result;
    logic                          hs;
    int                            beat_base;

    assign hs        = in_valid & in_ready;
    assign out_valid = (state == OUTPUT);
    assign busy      = (state != IDLE);
    assign dbg_state = state;

    // A beat accepted in IDLE is beat 0 regardless of the stale count left
    // by the previous frame.
    always_comb begin
        beat_base = (state == IDLE) ? 0 : int'(cnt) * lanes;
        for (int k = 0; k < lanes; k++) begin
            lane_mask[k] = (beat_base + k) < input_data_size;
        end
    end

    lane_dot_product #(
        .lanes      (lanes),
        .resolution (resolution)
    ) u_dot (
        .input_data (input_data),
        .weight     (weight),
        .lane_mask  (lane_mask),
        .beat_sum   (beat_sum)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = (beats == 1) ? FINISH : ACCUM;
                end
            end
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && (cnt == last_cnt)) begin
                    state_next = FINISH;
                end
            end
            FINISH: begin
                state_next = OUTPUT;
            end
            OUTPUT: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc    <= '0;
            cnt    <= '0;
            bias_q <= '0;
        end else if (hs) begin
            if (state == IDLE) begin
                acc    <= acc_w'(beat_sum);
                cnt    <= cnt_w'(1);
                bias_q <= bias;
            end else begin
                acc <= acc + acc_w'(beat_sum);
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Arithmetic right shift floors toward -inf; then ReLU, then clamp.
    always_comb begin
        biased  = acc + (acc_w'(bias_q) <<< frac_bits);
        shifted = biased >>> frac_bits;
        if ((relu_en != 0) && (shifted < 0)) begin
            result = '0;
        end else if (shifted > sat_hi) begin
            result = sat_hi[resolution-1:0];
        end else if (shifted < sat_lo) begin
            result = sat_lo[resolution-1:0];
        end else begin
            result = shifted[resolution-1:0];
        end
    end

    dff_nbit #(
        .n (resolution)
    ) u_out_reg (
        .clk   (clk),
        .reset (reset),
        .en    (state == FINISH),
        .d     (result),
        .q     (output_neuron)
    );

endmodule

// File: tb/tb_neuron_stream_mac.sv
// tb_neuron_stream_mac: directed bench over five configurations of
// neuron_stream_mac (lanes=4, resolution=8) with an arithmetic model.
module tb_neuron_stream_mac;

  localparam int NI = 5;

  function automatic int p_size(input int g);
    case (g)
      0: return 8;
      1: return 6;
      2: return 4;
      3: return 4;
      default: return 10;
    endcase
  endfunction

  function automatic int p_frac(input int g);
    return (g == 2 || g == 3) ? 6 : 0;
  endfunction

  function automatic int p_relu(input int g);
    return (g == 3) ? 1 : 0;
  endfunction

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0]        reset;
  logic [NI-1:0]        in_valid;
  logic [NI-1:0]        in_ready;
  logic [NI-1:0][31:0]  input_data;
  logic [NI-1:0][31:0]  weight;
  logic [NI-1:0][7:0]   bias;
  logic [NI-1:0]        out_valid;
  logic [NI-1:0]        out_ready;
  logic [NI-1:0][7:0]   output_neuron;
  logic [NI-1:0]        busy;
  logic [NI-1:0][1:0]   dbg_state;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    neuron_stream_mac #(
      .input_data_size (p_size(g)),
      .lanes           (4),
      .resolution      (8),
      .frac_bits       (p_frac(g)),
      .relu_en         (p_relu(g))
    ) u_dut (
      .clk           (clk),
      .reset         (reset[g]),
      .in_valid      (in_valid[g]),
      .in_ready      (in_ready[g]),
      .input_data    (input_data[g]),
      .weight        (weight[g]),
      .bias          (bias[g]),
      .out_valid     (out_valid[g]),
      .out_ready     (out_ready[g]),
      .output_neuron (output_neuron[g]),
      .busy          (busy[g]),
      .dbg_state     (dbg_state[g])
    );
  end

  // scoreboard
  int total = 0;
  int bad   = 0;
  int exp_q[$];
  int exp_g[$];
  int fx[16];
  int fw[16];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: exact sum over the real elements, floor-scaled bias add, ReLU, clamp.
  function automatic int model(input int g, input int b);
    longint s;
    longint r;
    s = 0;
    for (int i = 0; i < p_size(g); i++) s += longint'(fx[i]) * longint'(fw[i]);
    s += longint'(b) * (longint'(1) << p_frac(g));
    r = s >>> p_frac(g);
    if (p_relu(g) != 0 && r < 0) r = 0;
    if (r > 127) r = 127;
    if (r < -128) r = -128;
    return int'(r);
  endfunction

  // compare process: every cycle an output is offered
  logic [NI-1:0] held = '0;
  int held_v[NI];
  initial begin
    forever begin
      @(negedge clk);
      for (int g = 0; g < NI; g++) begin
        if (out_valid[g] === 1'b1) begin
          if (held[g]) check("out_stable", int'($signed(output_neuron[g])), held_v[g]);
          check("in_ready_during_out", int'(in_ready[g]), 0);
          check("busy_during_out", int'(busy[g]), 1);
          if (out_ready[g]) begin
            if (exp_q.size() == 0) begin
              check("unexpected_out", 1, 0);
            end else begin
              check("out_inst", g, exp_g[0]);
              check("out_value", int'($signed(output_neuron[g])), exp_q[0]);
              void'(exp_q.pop_front());
              void'(exp_g.pop_front());
            end
            held[g] = 1'b0;
          end else begin
            held[g]   = 1'b1;
            held_v[g] = int'($signed(output_neuron[g]));
          end
        end else begin
          held[g] = 1'b0;
        end
      end
    end
  end

  // driver tasks (all drive at posedge + 1)
  task automatic send_beat(input int g, input int b, input int bias_v);
    int t;
    for (int k = 0; k < 4; k++) begin
      input_data[g][k*8 +: 8] = 8'(fx[b*4 + k]);
      weight[g][k*8 +: 8]     = 8'(fw[b*4 + k]);
    end
    bias[g]     = 8'(bias_v);
    in_valid[g] = 1'b1;
    t = 0;
    @(negedge clk);
    while (!in_ready[g] && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("beat_accept_timeout", int'(in_ready[g]), 1);
    @(posedge clk);
    #1;
    in_valid[g] = 1'b0;
  endtask

  task automatic send_frame(input int g, input int bias_v, input int gap);
    int n;
    n = (p_size(g) + 3) / 4;
    exp_q.push_back(model(g, bias_v));
    exp_g.push_back(g);
    for (int b = 0; b < n; b++) begin
      // Later beats carry a junk bias that must be ignored.
      send_beat(g, b, (b == 0) ? bias_v : 85);
      if (b < n - 1) begin
        for (int i = 0; i < gap; i++) begin
          @(negedge clk);
          check("busy_in_gap", int'(busy[g]), 1);
          @(posedge clk);
          #1;
        end
      end
    end
  endtask

  task automatic wait_out();
    int t;
    t = 0;
    while (exp_q.size() > 0 && t < 60) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() > 0) begin
      check("out_timeout", 0, 1);
      exp_q.delete();
      exp_g.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int n, input int x, input int w);
    for (int i = 0; i < 16; i++) begin
      fx[i] = (i < n) ? x : 127;
      fw[i] = (i < n) ? w : 127;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int m;
    reset      = '1;
    in_valid   = '0;
    out_ready  = '1;
    input_data = '0;
    weight     = '0;
    bias       = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = '0;

    // reset state
    @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      check("rst_in_ready", int'(in_ready[g]), 1);
      check("rst_out_valid", int'(out_valid[g]), 0);
      check("rst_output", int'(output_neuron[g]), 0);
      check("rst_busy", int'(busy[g]), 0);
      check("rst_state", int'(dbg_state[g]), 0);
    end
    @(posedge clk);
    #1;

    // exact fit: 8 x (2*3) - 5 = 43, out_valid 2 cycles after last beat
    fill(8, 2, 3);
    m = model(0, -5);
    check("model_exact", m, 43);
    send_frame(0, -5, 0);
    @(negedge clk);
    check("lat_finish_no_valid", int'(out_valid[0]), 0);
    @(negedge clk);
    check("lat_valid", int'(out_valid[0]), 1);
    check("exact_value", int'($signed(output_neuron[0])), 43);
    wait_out();

    // partial last beat: 6 ones, lanes 6/7 carry 0x7F
    fill(6, 1, 1);
    m = model(1, 0);
    check("model_partial", m, 6);
    send_frame(1, 0, 0);
    wait_out();
    check("partial_value", int'($signed(output_neuron[1])), 6);

    // fixed point: 4 x 1.0*1.0 = 4.0 saturates to 0x7F
    fill(4, 64, 64);
    m = model(2, 0);
    check("model_sat_hi", m, 127);
    send_frame(2, 0, 0);
    wait_out();
    check("sat_hi_value", int'(output_neuron[2]), 8'h7F);

    // weight -1.0 -> -4.0 saturates to 0x80
    fill(4, 64, -64);
    m = model(2, 0);
    check("model_sat_lo", m, -128);
    send_frame(2, 0, 0);
    wait_out();
    check("sat_lo_value", int'(output_neuron[2]), 8'h80);

    // same negative frame with ReLU
    m = model(3, 0);
    check("model_relu", m, 0);
    send_frame(3, 0, 0);
    wait_out();
    check("relu_value", int'(output_neuron[3]), 0);

    // floor toward -inf: bias 0, sum -65 / 64 -> -2
    fill(4, 0, 0);
    fx[0] = -65;
    fw[0] = 1;
    m = model(2, 0);
    check("model_floor", m, -2);
    send_frame(2, 0, 0);
    wait_out();

    // backpressure: x = 1..8, w = 1 -> 36
    for (int i = 0; i < 16; i++) begin
      fx[i] = i + 1;
      fw[i] = 1;
    end
    out_ready[0] = 1'b0;
    send_frame(0, 0, 0);
    begin
      int t;
      t = 0;
      @(negedge clk);
      while (!out_valid[0] && t < 20) begin
        @(negedge clk);
        t++;
      end
      check("bp_valid", int'(out_valid[0]), 1);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      in_valid[0] = 1'b1;
      @(negedge clk);
      check("bp_hold_value", int'($signed(output_neuron[0])), 36);
      check("bp_in_ready", int'(in_ready[0]), 0);
    end
    @(posedge clk);
    #1;
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_release_valid", int'(out_valid[0]), 0);
    check("bp_release_ready", int'(in_ready[0]), 1);
    check("bp_release_busy", int'(busy[0]), 0);
    check("bp_queue_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;

    // valid gaps 1,0,0,1: same as the exact-fit frame
    fill(8, 2, 3);
    send_frame(0, -5, 2);
    wait_out();
    check("gap_value", int'($signed(output_neuron[0])), 43);

    // reset mid-frame after beat 1 of 3
    fill(4, 100, 100);
    send_beat(4, 0, 7);
    @(negedge clk);
    check("mid_busy", int'(busy[4]), 1);
    @(posedge clk);
    #1;
    reset[4] = 1'b1;
    @(posedge clk);
    #1;
    reset[4] = 1'b0;
    @(negedge clk);
    check("abort_out_valid", int'(out_valid[4]), 0);
    check("abort_output", int'(output_neuron[4]), 0);
    check("abort_busy", int'(busy[4]), 0);
    @(posedge clk);
    #1;
    fill(10, 1, 1);
    m = model(4, 0);
    check("model_after_abort", m, 10);
    send_frame(4, 0, 0);
    wait_out();
    check("after_abort_value", int'($signed(output_neuron[4])), 10);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/neuron_stream_mac.md
Name: neuron_stream_mac

Overview:
- Parametrised successor to the single-shot neuron wrapper.
- Computes one neuron output, ReLU/saturate(sum(x_i*w_i) + bias), over an input vector of arbitrary length.
- Inputs stream in `lanes` elements per beat over a valid/ready handshake; products accumulate across beats; the result is presented on a held valid/ready output.
- Sits between the pixel/feature buffer and the next layer's input register.

Parameters:
- input_data_size, 784: number of input elements per frame (>=1).
- lanes, 4: elements consumed per accepted beat (>=1).
- resolution, 8: bit width of each signed data, weight, bias and output value.
- frac_bits, 6: fractional bits of the shared fixed-point format (< resolution).
- relu_en, 1: 1 clamps negative results to 0; 0 passes signed results.

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: synchronous, active-high reset.
- in_valid, input, 1: beat on in_data/weight is valid.
- in_ready, output, 1: block accepts a beat this cycle.
- input_data, input, resolution*lanes: signed elements; lane k occupies bits [k*resolution +: resolution].
- weight, input, resolution*lanes: signed weights, same lane packing as input_data.
- bias, input, resolution: signed bias; sampled on the first beat of a frame.
- out_valid, output, 1: output_neuron holds a valid result.
- out_ready, input, 1: downstream accepts the result.
- output_neuron, output, resolution: signed result.
- busy, output, 1: a frame is in progress (any state other than IDLE).

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: in_ready=1, out_valid=0, output_neuron=0, busy=0; accumulator and beat counter cleared; state=IDLE.
- Reset mid-frame: aborts the frame with no output; the next accepted beat starts a new frame.
- Beat count: BEATS = ceil(input_data_size/lanes). A handshake is in_valid & in_ready.
- Last-beat masking: on the final beat, lanes with global index >= input_data_size contribute 0 regardless of data.
- State IDLE:
  - in_ready=1.
  - On handshake: sample bias, load acc = beat_sum, set cnt=1.
  - Go to FINISH if BEATS==1, else to ACCUM.
- State ACCUM:
  - in_ready=1.
  - On handshake: acc += beat_sum, cnt++.
  - When the handshake is the BEATS-th beat, go to FINISH.
  - No handshake means acc and cnt hold; in_valid gaps are legal.
- State FINISH (one cycle):
  - in_ready=0.
  - Compute r = (acc + (bias <<< frac_bits)) >>> frac_bits, arithmetic shift, i.e. truncation toward -inf.
  - If relu_en and r<0, set r=0.
  - Saturate r to [-2^(resolution-1), 2^(resolution-1)-1].
  - Register the result into output_neuron, set out_valid=1, go to OUTPUT.
- State OUTPUT:
  - in_ready=0; output_neuron and out_valid held stable.
  - On out_valid & out_ready: out_valid=0, go to IDLE. output_neuron keeps its last value.
  - A new frame may be accepted the cycle after the output handshake.
- Latency: out_valid rises 2 cycles after the clock edge that accepts the last beat.
- Throughput: one frame per BEATS+2 cycles, given continuous valid and ready.
- Widths:
  - Each product is 2*resolution signed bits.
  - beat_sum is 2*resolution + clog2(lanes) bits.
  - ACC_W = 2*resolution + clog2(input_data_size) + 1; the accumulator cannot overflow.
  - All arithmetic is signed with sign extension.
- Protocol rules:
  - in_data, weight and bias are only sampled on a handshake.
  - out_ready may be high before out_valid.
  - Beats offered while in_ready=0 are not consumed.

Decomposition:
- Package neuron_pkg holds:
  - state encodings IDLE/ACCUM/FINISH/OUTPUT (2-bit);
  - function clog2;
  - function computing ACC_W;
  - saturation bounds as functions of resolution.
- One sub-module, lane_dot_product (parameters lanes, resolution):
  - combinational signed multiply per lane plus adder tree producing beat_sum;
  - per-lane valid mask input for last-beat masking.
- Output register reuses the existing dff_nbit.

Test Plan:
- Exact-fit frame: input_data_size=8, lanes=4, frac_bits=0, relu_en=0, all x=2, w=3, bias=-5, 2 beats back-to-back -> out_valid 2 cycles after beat 2, output_neuron=43.
- Partial last beat: input_data_size=6, lanes=4, frac_bits=0, x=w=1, bias=0; beat 2 upper lanes driven to 0x7F -> output_neuron=6, garbage lanes ignored.
- Fixed point, saturation and ReLU:
  - frac_bits=6, relu_en=0, 4 inputs of 0x40 (1.0) times weight 0x40 -> 0x7F (saturated from 4.0).
  - Same frame with weight 0xC0 -> 0x80 (-128).
  - Same negative frame with relu_en=1 -> 0x00.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> output_neuron stable, in_ready=0 and extra beats not consumed; out_ready=1 -> out_valid drops the next cycle and in_ready=1.
- Valid gaps: in_valid toggled 1,0,0,1 across a 2-beat frame -> same result as back-to-back; busy=1 from the first beat until the output handshake.
- Reset mid-frame: reset for 1 cycle after beat 1 of 3 -> out_valid=0 and output_neuron=0; a subsequent full frame produces a correct result with no residue from the aborted beat.
